// File: rtl/code_pkg.sv
// ============================================================================
// code_pkg : shared types, default parameters and width helper for code_sender
// Rev 1.0
// ============================================================================
`default_nettype none

package code_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_CODE_W     = 4;
  localparam int unsigned DEF_BIT_CYCLES = 1;
  localparam int unsigned DEF_GAP_CYCLES = 2;
  localparam int unsigned DEF_REPEAT_W   = 3;

  // One counter serves both bit-hold and gap timing, so size it for the larger.
  function automatic int unsigned cnt_width(input int unsigned bit_cycles,
                                            input int unsigned gap_cycles);
    int unsigned m;
    m = 2;
    if (bit_cycles > m) m = bit_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/code_sender_if.sv
// ============================================================================
// code_sender_if : request / serial-output bundle of the code transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

interface code_sender_if #(
  parameter int unsigned CODE_W   = code_pkg::DEF_CODE_W,
  parameter int unsigned REPEAT_W = code_pkg::DEF_REPEAT_W
);
  logic                Start;
  logic [CODE_W-1:0]   Code;
  logic [REPEAT_W-1:0] Repeat;
  logic                D;
  logic                BitStrobe;
  logic                Busy;
  logic                Done;

  modport master (
    output Start, Code, Repeat,
    input  D, BitStrobe, Busy, Done
  );

  modport slave (
    input  Start, Code, Repeat,
    output D, BitStrobe, Busy, Done
  );
endinterface

`default_nettype wire

// File: rtl/code_bit_timer.sv
// ============================================================================
// code_bit_timer : loadable down-counter with terminal-count flag
// Rev 1.0
// ============================================================================
`default_nettype none

module code_bit_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/code_sender.sv
// ============================================================================
// code_sender : shifts a captured code word out MSB-first on D, Repeat+1
//               times, with a zero gap between copies
// Rev 1.0
// ============================================================================
`default_nettype none

module code_sender
  import code_pkg::*;
#(
  parameter int unsigned CODE_W     = DEF_CODE_W,
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned REPEAT_W   = DEF_REPEAT_W
) (
  input  logic          Clk,
  input  logic          Reset,
  code_sender_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(BIT_CYCLES, GAP_CYCLES);
  localparam int unsigned IDX_W = $clog2(CODE_W);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(CODE_W - 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   shreg_q, shreg_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [REPEAT_W-1:0] copies_q, copies_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                dout_q, dout_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_load_val;
  logic                tmr_tc;

  code_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    code_d       = code_q;
    copies_d     = copies_q;
    idx_d        = idx_q;
    tmr_load     = 1'b0;
    tmr_load_val = BIT_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          code_d   = bus.Code;
          shreg_d  = bus.Code;
          copies_d = bus.Repeat;
          idx_d    = IDX_TOP;
          tmr_load = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tmr_tc) begin
          if (idx_q != '0) begin
            shreg_d  = shreg_q << 1;
            idx_d    = idx_q - IDX_W'(1);
            tmr_load = 1'b1;
          end else if (copies_q != '0) begin
            // Next copy comes from the word captured at Start, not the live input.
            copies_d = copies_q - REPEAT_W'(1);
            shreg_d  = code_q;
            idx_d    = IDX_TOP;
            tmr_load = 1'b1;
            if (GAP_CYCLES != 0) begin
              state_d      = ST_GAP;
              tmr_load_val = GAP_LOAD;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state so they line up with state_q.
    dout_d   = (state_d == ST_SEND) && shreg_d[CODE_W-1];
    strobe_d = (state_d == ST_SEND) && tmr_load;
    busy_d   = (state_d == ST_SEND) || (state_d == ST_GAP);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      code_q   <= '0;
      copies_q <= '0;
      idx_q    <= '0;
      dout_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      code_q   <= code_d;
      copies_q <= copies_d;
      idx_q    <= idx_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.D         = dout_q;
  assign bus.BitStrobe = strobe_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_code_sender.sv
// ============================================================================
// tb_code_sender : directed self-checking bench for code_sender
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_code_sender;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  code_sender_if #(.CODE_W(4), .REPEAT_W(3)) bus0 ();
  code_sender_if #(.CODE_W(4), .REPEAT_W(3)) bus1 ();

  code_sender #(.CODE_W(4), .BIT_CYCLES(1), .GAP_CYCLES(2), .REPEAT_W(3)) dut0 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus0.slave)
  );

  code_sender #(.CODE_W(4), .BIT_CYCLES(3), .GAP_CYCLES(2), .REPEAT_W(3)) dut1 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic d, input logic s, input logic b, input logic dn);
    check({tag, ".D"},    32'(bus0.D),         32'(d));
    check({tag, ".strb"}, 32'(bus0.BitStrobe), 32'(s));
    check({tag, ".busy"}, 32'(bus0.Busy),      32'(b));
    check({tag, ".done"}, 32'(bus0.Done),      32'(dn));
  endtask

  task automatic chk1(input string tag, input logic d, input logic s, input logic b, input logic dn);
    check({tag, ".D"},    32'(bus1.D),         32'(d));
    check({tag, ".strb"}, 32'(bus1.BitStrobe), 32'(s));
    check({tag, ".busy"}, 32'(bus1.Busy),      32'(b));
    check({tag, ".done"}, 32'(bus1.Done),      32'(dn));
  endtask

  initial begin
    logic [3:0]  pat;
    logic [15:0] dexp, sexp;
    logic [11:0] bexp, nexp;
    int          nstrobe;

    rst = 1'b1;
    bus0.Start = 1'b0; bus0.Code = '0; bus0.Repeat = '0;
    bus1.Start = 1'b0; bus1.Code = '0; bus1.Repeat = '0;
    tick(); tick();
    chk0("reset0", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Single copy of 1011
    bus0.Code = 4'b1011; bus0.Repeat = 3'd0; bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk0($sformatf("t1.bit%0d", i), pat[3-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk0("t1.done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk0("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Three copies of 1100 with two-clock gaps
    bus0.Code = 4'b1100; bus0.Repeat = 3'd2; bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    dexp = 16'b1100_00_1100_00_1100;
    sexp = 16'b1111_00_1111_00_1111;
    nstrobe = 0;
    for (int i = 0; i < 16; i++) begin
      chk0($sformatf("t2.c%0d", i), dexp[15-i], sexp[15-i], 1'b1, 1'b0);
      nstrobe += int'(bus0.BitStrobe);
      tick();
    end
    check("t2.strobes", 32'(nstrobe), 32'd12);
    chk0("t2.done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Live Code change and Start mid-transfer, and Start during DONE, are ignored
    bus0.Code = 4'b1111; bus0.Repeat = 3'd0; bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk0($sformatf("t4.bit%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 1) begin
        bus0.Code  = 4'b0000;
        bus0.Start = 1'b1;
      end else begin
        bus0.Start = 1'b0;
      end
      tick();
    end
    chk0("t4.done", 1'b0, 1'b0, 1'b0, 1'b1);
    bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk0($sformatf("t4.quiet%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // Reset on the third bit of a two-copy transfer
    bus0.Code = 4'b1011; bus0.Repeat = 3'd1; bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    chk0("t5.b0", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk0("t5.b1", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk0("t5.b2", 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk0("t5.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk0($sformatf("t5.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    bus0.Code = 4'b0110; bus0.Repeat = 3'd0; bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      chk0($sformatf("t5.new%0d", i), pat[3-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk0("t5.done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Start held high: a new transfer every busy-time + 2 clocks
    bus0.Code = 4'b1010; bus0.Repeat = 3'd0; bus0.Start = 1'b1;
    tick();
    bexp = 12'b1111_00_1111_00;
    nexp = 12'b0000_10_0000_10;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t6.busy%0d", i), 32'(bus0.Busy), 32'(bexp[11-i]));
      check($sformatf("t6.done%0d", i), 32'(bus0.Done), 32'(nexp[11-i]));
      if (i == 11) bus0.Start = 1'b0;
      tick();
    end
    for (int i = 0; i < 6; i++) tick();
    chk0("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Three clocks per bit on the second instance
    bus1.Code = 4'b0110; bus1.Repeat = 3'd0; bus1.Start = 1'b1;
    tick();
    bus1.Start = 1'b0;
    pat = 4'b0110;
    for (int i = 0; i < 12; i++) begin
      chk1($sformatf("t3.c%0d", i), pat[3-i/3], (i % 3) == 0, 1'b1, 1'b0);
      tick();
    end
    chk1("t3.done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk1("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
